// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs,
// pipe control outputs and performance counters.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             rs1_used_ID;
  logic             rs2_used_ID;
  logic [4:0]       rd_EX;
  logic             mem_read_EX;
  logic             pc_select;
  logic             imem_busywait;
  logic             dmem_busywait;
  logic             stall_pc;
  logic             stall_IF_ID;
  logic             bubble_ID_EX;
  logic             flush_IF_ID;
  logic             busywait_pipe;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] busy_count;

  modport master (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
    input  rd_EX, mem_read_EX, pc_select,
    input  imem_busywait, dmem_busywait,
    output stall_pc, stall_IF_ID, bubble_ID_EX,
    output flush_IF_ID, busywait_pipe, mem_timeout,
    output stall_count, flush_count, busy_count
  );

  modport slave (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
    output rd_EX, mem_read_EX, pc_select,
    output imem_busywait, dmem_busywait,
    input  stall_pc, stall_IF_ID, bubble_ID_EX,
    input  flush_IF_ID, busywait_pipe, mem_timeout,
    input  stall_count, flush_count, busy_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// memory freeze, saturating counters and memory watchdog.
module hazard_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_ctrl_if.master hz
);
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_TMO  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SAT = '1;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  logic busy;
  logic load_use;
  logic do_stall;
  logic do_flush;

  assign busy = hz.imem_busywait | hz.dmem_busywait;
  assign load_use = hz.mem_read_EX && (hz.rd_EX != 5'd0) &&
    ((hz.rs1_used_ID && hz.rs1_ID == hz.rd_EX) ||
     (hz.rs2_used_ID && hz.rs2_ID == hz.rd_EX));

  // Prioritised pipe controls, forced idle while in reset
  always_comb begin
    hz.stall_pc      = 1'b0;
    hz.stall_IF_ID   = 1'b0;
    hz.bubble_ID_EX  = 1'b0;
    hz.flush_IF_ID   = 1'b0;
    hz.busywait_pipe = 1'b0;
    do_stall         = 1'b0;
    do_flush         = 1'b0;
    if (reset) begin
      priority case (1'b1)
        busy: hz.busywait_pipe = 1'b1;
        hz.pc_select: begin
          hz.flush_IF_ID  = 1'b1;
          hz.bubble_ID_EX = 1'b1;
          do_flush        = 1'b1;
        end
        load_use: begin
          hz.stall_pc     = 1'b1;
          hz.stall_IF_ID  = 1'b1;
          hz.bubble_ID_EX = 1'b1;
          do_stall        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Watchdog FSM and saturating counter next values
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    tmo_d       = tmo_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (busy) begin
          state_d    = S_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      S_WAIT: begin
        if (busy && wait_cnt_q == 16'(TIMEOUT)) begin
          state_d = S_TMO;
          tmo_d   = 1'b1;
        end else if (busy) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
          state_d    = S_RUN;
          wait_cnt_d = 16'd0;
        end
      end
      S_TMO: begin
        if (!busy) begin
          state_d    = S_RUN;
          wait_cnt_d = 16'd0;
        end
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = 16'd0;
      end
    endcase
    if (do_stall && stall_cnt_q != SAT)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (do_flush && flush_cnt_q != SAT)
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (busy && busy_cnt_q != SAT)
      busy_cnt_d = busy_cnt_q + 1'b1;
  end

  // State, watchdog and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 16'd0;
      tmo_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign hz.mem_timeout = tmo_q;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
  assign hz.busy_count  = busy_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, corner
// sequences and random traffic against a reference model.
module tb_hazard_stall_ctrl;
  localparam int CW  = 4;
  localparam int TMO = 3;
  localparam int SAT = 15;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int m_stall, m_flush, m_busy, m_run;
  bit m_tmo;

  hazard_stall_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_stall_ctrl #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, pcs, ib, db;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ctrl_now();
    return {hz.stall_pc, hz.stall_IF_ID, hz.bubble_ID_EX,
            hz.flush_IF_ID, hz.busywait_pipe};
  endfunction

  function automatic bit m_loaduse();
    if (!hz.mem_read_EX || hz.rd_EX == 0) return 0;
    return (hz.rs1_used_ID && hz.rs1_ID == hz.rd_EX) ||
           (hz.rs2_used_ID && hz.rs2_ID == hz.rd_EX);
  endfunction

  // {stall_pc, stall_IF_ID, bubble, flush, busywait}
  function automatic logic [4:0] m_ctrl();
    if (hz.imem_busywait || hz.dmem_busywait) return 5'b00001;
    if (hz.pc_select) return 5'b00110;
    if (m_loaduse()) return 5'b11100;
    return 5'b00000;
  endfunction

  function automatic int sat_inc(input int v, input bit en);
    return (en && v < SAT) ? v + 1 : v;
  endfunction

  task automatic set_in(input logic [4:0] rs1, rs2, rd,
                        input logic u1, u2, mr, pcs, ib, db);
    hz.rs1_ID = rs1; hz.rs2_ID = rs2; hz.rd_EX = rd;
    hz.rs1_used_ID = u1; hz.rs2_used_ID = u2;
    hz.mem_read_EX = mr; hz.pc_select = pcs;
    hz.imem_busywait = ib; hz.dmem_busywait = db;
  endtask

  // One cycle: check against model, clock, advance model.
  task automatic step();
    logic [4:0] e;
    bit busy;
    #1;
    e = m_ctrl();
    busy = hz.imem_busywait || hz.dmem_busywait;
    chk("ctrl", int'(ctrl_now()), int'(e));
    chk("stall_count", int'(hz.stall_count), m_stall);
    chk("flush_count", int'(hz.flush_count), m_flush);
    chk("busy_count", int'(hz.busy_count), m_busy);
    chk("mem_timeout", int'(hz.mem_timeout), int'(m_tmo));
    @(posedge clk);
    m_stall = sat_inc(m_stall, e == 5'b11100);
    m_flush = sat_inc(m_flush, e == 5'b00110);
    m_busy  = sat_inc(m_busy, busy);
    m_run   = busy ? m_run + 1 : 0;
    if (m_run > TMO) m_tmo = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_ctrl", int'(ctrl_now()), 0);
    chk("rst_counts", int'(hz.stall_count) + int'(hz.flush_count)
        + int'(hz.busy_count), 0);
    chk("rst_timeout", int'(hz.mem_timeout), 0);
    m_stall = 0; m_flush = 0; m_busy = 0; m_run = 0; m_tmo = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{5, 0, 5, 1, 0, 1, 0, 0, 0, 5'b11100};
    tbl[1] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 5'b00000};
    tbl[2] = '{0, 5, 5, 0, 0, 1, 0, 0, 0, 5'b00000};
    tbl[3] = '{0, 7, 7, 0, 1, 1, 0, 0, 0, 5'b11100};
    tbl[4] = '{5, 0, 5, 1, 0, 1, 1, 0, 0, 5'b00110};
    tbl[5] = '{5, 0, 5, 1, 0, 1, 1, 0, 1, 5'b00001};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001};
    tbl[7] = '{9, 9, 9, 1, 1, 0, 0, 0, 0, 5'b00000};
    tbl[8] = '{3, 3, 4, 1, 1, 1, 0, 0, 0, 5'b00000};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00110};
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1,
             tbl[i].u2, tbl[i].mr, tbl[i].pcs, tbl[i].ib, tbl[i].db);
      #1;
      chk($sformatf("vec%0d", i), int'(ctrl_now()), int'(tbl[i].exp));
      step();
    end

    // single load-use stall, then bubble in EX
    do_reset();
    set_in(5, 0, 5, 1, 0, 1, 0, 0, 0);
    step();
    set_in(5, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("t1_stall_count", int'(hz.stall_count), 1);
    chk("t1_released", int'(ctrl_now()), 0);
    step();

    // branch overrides load-use
    do_reset();
    set_in(5, 0, 5, 1, 0, 1, 1, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t3_flush_count", int'(hz.flush_count), 1);
    chk("t3_stall_count", int'(hz.stall_count), 0);
    step();

    // pc_select held across a 4-cycle dmem freeze
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
      #1;
      chk("t4_frozen", int'(ctrl_now()), 1);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("t4_busy_count", int'(hz.busy_count), 4);
    chk("t4_flush_fires", int'(ctrl_now()), 6);
    step();
    #1;
    chk("t4_flush_count", int'(hz.flush_count), 1);

    // watchdog: 10 imem busy cycles
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step();
      #1;
      chk($sformatf("t5_tmo_c%0d", i), int'(hz.mem_timeout), int'(i >= 4));
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    #1;
    chk("t5_sticky", int'(hz.mem_timeout), 1);
    do_reset();

    // stall counter saturation
    for (int i = 0; i < 20; i++) begin
      set_in(2, 0, 2, 1, 0, 1, 0, 0, 0);
      step();
    end
    #1;
    chk("t6_saturated", int'(hz.stall_count), SAT);

    // reset in the middle of a memory wait
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step();
    step();
    do_reset();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
